alu_multicycle: RTL and testbench
=================================

Name: alu_multicycle

Overview:
Parametrised successor to the single-cycle datapath ALU. Adds valid/ready handshakes on input and output, plus a registered result stage. Extends the op set with XOR, shifts, set-less-than and an iterative shift-add multiplier, optionally joined by an iterative unsigned divider. Sits in the execute stage and stalls the pipeline through in_ready while a multi-cycle op runs.

Parameters:
DATA_WIDTH, 32 (RISC_V_DATA_WIDTH), operand/result width; must be a power of 2, ≥8
OP_WIDTH, 4, width of op select
SHAMT_WIDTH, $clog2(DATA_WIDTH), shift-amount bits taken from data_in_B

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operands/op presented
in_ready  out  1  block can accept an op this cycle
data_in_A  in  DATA_WIDTH  operand A (signed interpretation where noted)
data_in_B  in  DATA_WIDTH  operand B
op  in  OP_WIDTH  operation select
out_valid  out  1  result held on data_out
out_ready  in  1  consumer takes result
data_out  out  DATA_WIDTH  registered result
zero  out  1  registered, 1 when data_out == 0
busy  out  1  multi-cycle op in progress

Behaviour:
- One clock. Reset is synchronous and active-high.
- Op encoding: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed), 9 SLTU, 10 MUL (low half of product), 11 MULHU (high half, unsigned×unsigned), 12 DIVU, 13 REMU. All others return 0.
- ADD/SUB wrap modulo 2^DATA_WIDTH; no overflow flag.
- Shifts use data_in_B[SHAMT_WIDTH-1:0] only.
- SLT/SLTU return 1 or 0, zero-extended.
- FSM states:
  - IDLE: no op in flight.
  - MUL: iterative multiply running.
  - DIV: iterative divide running.
- Handshake:
  - Accept occurs when in_valid && in_ready on a rising edge.
  - in_ready = (state==IDLE) && (!out_valid || out_ready). A result being drained in the same cycle does not block a new accept.
  - Result transfers when out_valid && out_ready.
  - data_out, zero and out_valid stay stable while out_valid && !out_ready.
- Single-cycle ops (0-9, plus unknown codes): the result is registered on the accept edge, so out_valid rises the cycle after accept (latency 1).
  - Back-to-back accepts with out_ready held at 1 give one result per cycle.
- MUL/MULHU:
  - Accept latches A and B (unsigned) and moves to MUL.
  - One shift-add step per cycle for DATA_WIDTH cycles into a 2*DATA_WIDTH-bit accumulator.
  - Then return to IDLE with out_valid=1; latency DATA_WIDTH+1 from accept.
  - busy=1 in MUL.
- in_valid while busy: ignored, because in_ready=0. Operands are not re-sampled.
- Reset:
  - Resets at any cycle, including mid-MUL/DIV, and aborts the op.
  - state=IDLE, out_valid=0, data_out=0, zero=0, busy=0, iteration counter=0.
  - in_ready=1 in the first cycle after reset deasserts.
- zero:
  - Computed from the value loaded into data_out, on the same edge.
  - Meaningful only while out_valid=1.

Optional Feature:
Macro ALU_MULTICYCLE_DIV_EN.
- Defined:
  - DIVU/REMU run as restoring division in state DIV, one quotient bit per cycle, DATA_WIDTH cycles; latency DATA_WIDTH+1.
  - Divide by zero: DIVU returns all ones and REMU returns data_in_A (RISC-V semantics), still after the full latency.
- Not defined:
  - The DIV state and divider datapath are absent.
  - Ops 12/13 behave as unknown codes: single-cycle, result 0, zero=1.

Test Plan:
- Reset then ADD A=0x7FFFFFFF, B=1 → one cycle later out_valid=1, data_out=0x80000000, zero=0. SUB A=5, B=5 → data_out=0, zero=1.
- SRA A=0x80000000, B=0x24 (shamt 4) → 0xF8000000. SLT A=-1, B=1 → 1. SLTU A=0xFFFFFFFF, B=1 → 0.
- MUL A=0xFFFFFFFF, B=2 → in_ready=0 and busy=1 for 32 cycles; out_valid on cycle 33 with 0xFFFFFFFE. MULHU with the same operands → 0x00000001.
- Backpressure: hold out_ready=0 after an AND result 0x0F → data_out stays 0x0F and in_ready=0 for 10 cycles. Raise out_ready with in_valid=1 (OR A=1, B=2) → same-cycle accept, next result 0x3.
- Assert rst on cycle 10 of a MUL → next cycle state IDLE, out_valid=0, data_out=0, busy=0, in_ready=1. A subsequent ADD 2+3 → 5.
- With ALU_MULTICYCLE_DIV_EN: DIVU 100/7 → 14 after 33 cycles, REMU → 2, DIVU x/0 → 0xFFFFFFFF, REMU 9/0 → 9. Without the macro: DIVU → 0 after 1 cycle, zero=1.

Source files
------------

// File: rtl/alu_multicycle.sv
// Purpose: execute-stage ALU with valid/ready handshakes, an iterative shift-add multiplier and an optional restoring divider.
// Latency: 1 cycle for single-cycle ops, DATA_WIDTH+1 cycles for MUL/MULHU (and DIVU/REMU when enabled).
// Backpressure: in_ready drops while a multi-cycle op runs or while an undrained result is held; the output holds until out_ready.
//
// Ports:
//   clk, rst               single rising-edge clock, synchronous active-high reset
//   in_valid / in_ready    operand handshake (data_in_A, data_in_B, op)
//   out_valid / out_ready  result handshake (data_out, zero)
//   busy                   multi-cycle op in progress
// Optional feature macro: ALU_MULTICYCLE_DIV_EN enables DIVU/REMU (ops 12/13) as an iterative divider;
// without it those codes behave like any unknown op (single-cycle, result 0).
module alu_multicycle #(
  parameter int DATA_WIDTH  = 32,
  parameter int OP_WIDTH    = 4,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] data_in_A,
  input  logic [DATA_WIDTH-1:0] data_in_B,
  input  logic [OP_WIDTH-1:0]   op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  zero,
  output logic                  busy
);

  localparam logic [OP_WIDTH-1:0] OP_AND   = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_OR    = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_ADD   = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_SUB   = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_XOR   = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_SLL   = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OP_SRL   = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] OP_SRA   = OP_WIDTH'(7);
  localparam logic [OP_WIDTH-1:0] OP_SLT   = OP_WIDTH'(8);
  localparam logic [OP_WIDTH-1:0] OP_SLTU  = OP_WIDTH'(9);
  localparam logic [OP_WIDTH-1:0] OP_MUL   = OP_WIDTH'(10);
  localparam logic [OP_WIDTH-1:0] OP_MULHU = OP_WIDTH'(11);
`ifdef ALU_MULTICYCLE_DIV_EN
  localparam logic [OP_WIDTH-1:0] OP_DIVU  = OP_WIDTH'(12);
  localparam logic [OP_WIDTH-1:0] OP_REMU  = OP_WIDTH'(13);
`endif

  localparam logic [SHAMT_WIDTH-1:0] CNT_LAST = SHAMT_WIDTH'(DATA_WIDTH - 1);
  localparam logic [SHAMT_WIDTH-1:0] CNT_ONE  = SHAMT_WIDTH'(1);

`ifdef ALU_MULTICYCLE_DIV_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1} state_t;
`endif

  state_t                    state;
  logic [SHAMT_WIDTH-1:0]    cnt;
  // Shared iteration register: MUL keeps {partial product, multiplier}, DIV keeps {remainder, dividend/quotient}.
  logic [2*DATA_WIDTH-1:0]   acc;
  logic [DATA_WIDTH-1:0]     opnd;    // multiplicand or divisor
  logic                      hi_sel;  // result comes from the upper half of acc (MULHU / REMU)

  logic                      accept;
  logic [SHAMT_WIDTH-1:0]    shamt;
  logic [DATA_WIDTH-1:0]     alu_res;
  logic [DATA_WIDTH:0]       mul_sum;
  logic [2*DATA_WIDTH-1:0]   mul_next;
  logic [2*DATA_WIDTH-1:0]   step_next;
  logic [DATA_WIDTH-1:0]     step_res;

  assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign shamt    = data_in_B[SHAMT_WIDTH-1:0];

  always_comb begin
    alu_res = '0;
    case (op)
      OP_AND:  alu_res = data_in_A & data_in_B;
      OP_OR:   alu_res = data_in_A | data_in_B;
      OP_ADD:  alu_res = data_in_A + data_in_B;
      OP_SUB:  alu_res = data_in_A - data_in_B;
      OP_XOR:  alu_res = data_in_A ^ data_in_B;
      OP_SLL:  alu_res = data_in_A << shamt;
      OP_SRL:  alu_res = data_in_A >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(data_in_A) >>> shamt);
      OP_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(data_in_A) < $signed(data_in_B))};
      OP_SLTU: alu_res = {{(DATA_WIDTH-1){1'b0}}, (data_in_A < data_in_B)};
      default: alu_res = '0;
    endcase
  end

  // Shift-add step: add the multiplicand into the upper half when the current
  // multiplier LSB is set, then shift the whole accumulator right by one.
  assign mul_sum  = {1'b0, acc[2*DATA_WIDTH-1:DATA_WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_next = {mul_sum, acc[DATA_WIDTH-1:1]};

`ifdef ALU_MULTICYCLE_DIV_EN
  // Restoring step: shift the next dividend bit into the remainder and subtract
  // the divisor when it fits. A zero divisor always "fits", which yields an
  // all-ones quotient and the dividend as remainder without special casing.
  logic [DATA_WIDTH:0]     div_trial;
  logic                    div_fits;
  logic [DATA_WIDTH-1:0]   div_rem;
  logic [2*DATA_WIDTH-1:0] div_next;

  assign div_trial = acc[2*DATA_WIDTH-1:DATA_WIDTH-1];
  assign div_fits  = div_trial >= {1'b0, opnd};
  assign div_rem   = div_fits ? (div_trial[DATA_WIDTH-1:0] - opnd) : div_trial[DATA_WIDTH-1:0];
  assign div_next  = {div_rem, acc[DATA_WIDTH-2:0], div_fits};
  assign step_next = (state == S_DIV) ? div_next : mul_next;
`else
  assign step_next = mul_next;
`endif

  assign step_res = hi_sel ? step_next[2*DATA_WIDTH-1:DATA_WIDTH] : step_next[DATA_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      acc       <= '0;
      opnd      <= '0;
      hi_sel    <= 1'b0;
      out_valid <= 1'b0;
      data_out  <= '0;
      zero      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (op == OP_MUL || op == OP_MULHU) begin
              state  <= S_MUL;
              busy   <= 1'b1;
              cnt    <= '0;
              acc    <= {{DATA_WIDTH{1'b0}}, data_in_B};
              opnd   <= data_in_A;
              hi_sel <= (op == OP_MULHU);
            end
`ifdef ALU_MULTICYCLE_DIV_EN
            else if (op == OP_DIVU || op == OP_REMU) begin
              state  <= S_DIV;
              busy   <= 1'b1;
              cnt    <= '0;
              acc    <= {{DATA_WIDTH{1'b0}}, data_in_A};
              opnd   <= data_in_B;
              hi_sel <= (op == OP_REMU);
            end
`endif
            else begin
              data_out  <= alu_res;
              zero      <= (alu_res == '0);
              out_valid <= 1'b1;
            end
          end
        end
        default: begin
          // Entry into a multi-cycle state required the output to be drained,
          // so loading the result on the last step never overwrites a live one.
          acc <= step_next;
          cnt <= cnt + CNT_ONE;
          if (cnt == CNT_LAST) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            data_out  <= step_res;
            zero      <= (step_res == '0);
            out_valid <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
module tb_alu_multicycle;

  localparam int W       = 32;
  localparam int MC_LAT  = W + 1;
  localparam int TIMEOUT = 200;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  data_in_A;
  logic [W-1:0]  data_in_B;
  logic [3:0]    op;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  data_out;
  logic          zero;
  logic          busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_multicycle #(.DATA_WIDTH(W), .OP_WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in_A (data_in_A),
    .data_in_B (data_in_B),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .zero      (zero),
    .busy      (busy)
  );

  // Behavioural reference: plain arithmetic on the operands.
  function automatic logic [W-1:0] ref_result(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] prod;
    prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (o)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd3:  return a - b;
      4'd4:  return a ^ b;
      4'd5:  return a << b[4:0];
      4'd6:  return a >> b[4:0];
      4'd7:  return $unsigned($signed(a) >>> b[4:0]);
      4'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:  return (a < b) ? 32'd1 : 32'd0;
      4'd10: return prod[W-1:0];
      4'd11: return prod[2*W-1:W];
`ifdef ALU_MULTICYCLE_DIV_EN
      4'd12: return (b == 0) ? {W{1'b1}} : a / b;
      4'd13: return (b == 0) ? a : a % b;
`endif
      default: return '0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] o);
    if (o == 4'd10 || o == 4'd11) return MC_LAT;
`ifdef ALU_MULTICYCLE_DIV_EN
    if (o == 4'd12 || o == 4'd13) return MC_LAT;
`endif
    return 1;
  endfunction

  // Runs one transaction with out_ready=1 and reports what the DUT produced.
  // lat counts cycles from the accept edge until out_valid is seen.
  task automatic run_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] res, output logic z, output int lat,
                        output int busy_cnt, output bit timed_out);
    int  k;
    bit  acc;
    timed_out = 0;
    busy_cnt  = 0;
    op = o; data_in_A = a; data_in_B = b; in_valid = 1'b1; out_ready = 1'b1;
    k = 0; acc = 0;
    while (!acc && k < TIMEOUT) begin
      #1;
      acc = in_ready;
      @(posedge clk); #1;
      k++;
    end
    if (!acc) timed_out = 1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < TIMEOUT) begin
      if (busy && !in_ready) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) timed_out = 1;
    res = data_out;
    z   = zero;
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; data_in_A = '0; data_in_B = '0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; #1;
    checks++;
    if (out_valid !== 1'b0 || data_out !== '0 || zero !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got ov=%b do=%h z=%b busy=%b ir=%b expected ov=0 do=0 z=0 busy=0 ir=1",
               out_valid, data_out, zero, busy, in_ready);
    end
  endtask

  task automatic test_single_cycle();
    logic [3:0]   t_op [9] = '{4'd2, 4'd3, 4'd7, 4'd8, 4'd9, 4'd4, 4'd5, 4'd6, 4'd14};
    logic [W-1:0] t_a  [9] = '{32'h7FFFFFFF, 32'd5, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0000F0F0, 32'd1, 32'h80000000, 32'd5};
    logic [W-1:0] t_b  [9] = '{32'd1, 32'd5, 32'h24, 32'd1, 32'd1, 32'h0000FF00, 32'h21, 32'd31, 32'd5};
    logic [W-1:0] t_r  [9] = '{32'h80000000, 32'd0, 32'hF8000000, 32'd1, 32'd0, 32'h00000FF0, 32'd2, 32'd1, 32'd0};
    logic [W-1:0] res;
    logic z;
    int lat, bc;
    bit to;
    for (int i = 0; i < 9; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], res, z, lat, bc, to);
      checks++;
      if (to || res !== t_r[i] || z !== (t_r[i] == 0) || lat != 1) begin
        errors++;
        $display("FAIL single_cycle[%0d] op=%0d: got res=%h z=%b lat=%0d to=%0b expected res=%h z=%b lat=1",
                 i, t_op[i], res, z, lat, to, t_r[i], (t_r[i] == 0));
      end
    end
  endtask

  task automatic test_mul();
    logic [W-1:0] res;
    logic z;
    int lat, bc;
    bit to;
    run_op(4'd10, 32'hFFFFFFFF, 32'd2, res, z, lat, bc, to);
    checks++;
    if (to || res !== 32'hFFFFFFFE || z !== 1'b0 || lat != MC_LAT || bc != W) begin
      errors++;
      $display("FAIL mul: got res=%h z=%b lat=%0d busy_cycles=%0d expected res=fffffffe z=0 lat=%0d busy_cycles=%0d",
               res, z, lat, bc, MC_LAT, W);
    end
    run_op(4'd11, 32'hFFFFFFFF, 32'd2, res, z, lat, bc, to);
    checks++;
    if (to || res !== 32'h00000001 || lat != MC_LAT || bc != W) begin
      errors++;
      $display("FAIL mulhu: got res=%h lat=%0d busy_cycles=%0d expected res=00000001 lat=%0d busy_cycles=%0d",
               res, lat, bc, MC_LAT, W);
    end
  endtask

  task automatic test_div();
    logic [W-1:0] res;
    logic z;
    int lat, bc;
    bit to;
`ifdef ALU_MULTICYCLE_DIV_EN
    logic [3:0]   t_op [4] = '{4'd12, 4'd13, 4'd12, 4'd13};
    logic [W-1:0] t_a  [4] = '{32'd100, 32'd100, 32'h12345678, 32'd9};
    logic [W-1:0] t_b  [4] = '{32'd7, 32'd7, 32'd0, 32'd0};
    logic [W-1:0] t_r  [4] = '{32'd14, 32'd2, 32'hFFFFFFFF, 32'd9};
    for (int i = 0; i < 4; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], res, z, lat, bc, to);
      checks++;
      if (to || res !== t_r[i] || lat != MC_LAT || bc != W) begin
        errors++;
        $display("FAIL div[%0d]: got res=%h lat=%0d busy_cycles=%0d expected res=%h lat=%0d busy_cycles=%0d",
                 i, res, lat, bc, t_r[i], MC_LAT, W);
      end
    end
`else
    run_op(4'd12, 32'd100, 32'd7, res, z, lat, bc, to);
    checks++;
    if (to || res !== '0 || z !== 1'b1 || lat != 1) begin
      errors++;
      $display("FAIL divu_disabled: got res=%h z=%b lat=%0d expected res=0 z=1 lat=1", res, z, lat);
    end
    run_op(4'd13, 32'd9, 32'd4, res, z, lat, bc, to);
    checks++;
    if (to || res !== '0 || z !== 1'b1 || lat != 1) begin
      errors++;
      $display("FAIL remu_disabled: got res=%h z=%b lat=%0d expected res=0 z=1 lat=1", res, z, lat);
    end
`endif
  endtask

  task automatic test_backpressure();
    int good;
    drain();
    out_ready = 1'b0;
    op = 4'd0; data_in_A = 32'h0000000F; data_in_B = 32'h000000FF; in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_initial_ready: got %b expected 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    good = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid === 1'b1 && data_out === 32'h0F && zero === 1'b0 && in_ready === 1'b0) good++;
      @(posedge clk); #1;
    end
    checks++;
    if (good != 10) begin
      errors++;
      $display("FAIL bp_hold: got %0d stable cycles expected 10", good);
    end
    op = 4'd1; data_in_A = 32'd1; data_in_B = 32'd2; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_same_cycle_ready: got %b expected 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || data_out !== 32'h3 || zero !== 1'b0) begin
      errors++;
      $display("FAIL bp_next_result: got ov=%b do=%h z=%b expected ov=1 do=00000003 z=0", out_valid, data_out, zero);
    end
  endtask

  task automatic test_reset_mid_mul();
    logic [W-1:0] res;
    logic z;
    int lat, bc;
    bit to;
    drain();
    op = 4'd10; data_in_A = 32'hFFFFFFFF; data_in_B = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_mul_busy: got %b expected 1", busy);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; #1;
    checks++;
    if (out_valid !== 1'b0 || data_out !== '0 || busy !== 1'b0 || in_ready !== 1'b1 || zero !== 1'b0) begin
      errors++;
      $display("FAIL mid_mul_reset: got ov=%b do=%h busy=%b ir=%b z=%b expected ov=0 do=0 busy=0 ir=1 z=0",
               out_valid, data_out, busy, in_ready, zero);
    end
    run_op(4'd2, 32'd2, 32'd3, res, z, lat, bc, to);
    checks++;
    if (to || res !== 32'd5 || lat != 1) begin
      errors++;
      $display("FAIL after_reset_add: got res=%h lat=%0d expected res=00000005 lat=1", res, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]   b_op [8];
    logic [W-1:0] b_a  [8];
    logic [W-1:0] b_b  [8];
    for (int i = 0; i < 8; i++) begin
      b_op[i] = 4'($urandom_range(0, 9));
      b_a[i]  = $urandom;
      b_b[i]  = $urandom;
    end
    drain();
    out_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        op = b_op[i]; data_in_A = b_a[i]; data_in_B = b_b[i]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (i > 0) begin
        checks++;
        if (out_valid !== 1'b1 || data_out !== ref_result(b_op[i-1], b_a[i-1], b_b[i-1])) begin
          errors++;
          $display("FAIL back_to_back[%0d]: got ov=%b do=%h expected ov=1 do=%h",
                   i - 1, out_valid, data_out, ref_result(b_op[i-1], b_a[i-1], b_b[i-1]));
        end
      end
      if (i < 8) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL back_to_back_ready[%0d]: got %b expected 1", i, in_ready);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    logic [3:0]   o;
    logic [W-1:0] a, b, res, exp_r;
    logic z;
    int lat, bc;
    bit to;
    for (int i = 0; i < 150; i++) begin
      o = 4'($urandom_range(0, 15));
      a = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255)) : W'($urandom);
      case ($urandom_range(0, 5))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        default: b = W'($urandom);
      endcase
      exp_r = ref_result(o, a, b);
      run_op(o, a, b, res, z, lat, bc, to);
      checks++;
      if (to || res !== exp_r || z !== (exp_r == 0) || lat != ref_latency(o)) begin
        errors++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: got res=%h z=%b lat=%0d expected res=%h z=%b lat=%0d",
                 i, o, a, b, res, z, lat, exp_r, (exp_r == 0), ref_latency(o));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_mul();
    test_div();
    test_backpressure();
    test_reset_mid_mul();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
